// File: rtl/constants_pkg.sv
// Shared fetch-path constants: the canonical NOP and the default boot vector.
package constants_pkg;
  localparam logic [31:0] NOP_INST          = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_BOOT_ADDR = 32'h0000_0000;
endpackage

// File: rtl/instruction_pkg.sv
// Prefetch queue entry layout: the fetched PC paired with its instruction word.
package instruction_pkg;
  localparam int unsigned FE_ARCH_LEN = 32;
  localparam int unsigned FE_INST_LEN = 32;

  typedef struct packed {
    logic [FE_ARCH_LEN-1:0] pc;
    logic [FE_INST_LEN-1:0] inst;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// Circular prefetch FIFO with synchronous flush; reset clears only pointers and count.
module fetch_queue
  import instruction_pkg::*;
#(
  parameter type         entry_t = fetch_entry_t,
  parameter int unsigned DEPTH   = 4
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push,
  input  logic   pop,
  input  logic   flush,
  input  entry_t wr_data,
  output entry_t head,
  output logic   full,
  output logic   empty
);
  localparam int unsigned PW = $clog2(DEPTH);

  entry_t          mem [DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [PW:0]     count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= wr_data;
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == (PW+1)'(DEPTH));
  assign empty = (count == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      assert (count <= (PW+1)'(DEPTH));
      if (pop)  assert (!empty);
      if (push) assert (!full || pop);
    end
  end
endmodule

// File: rtl/fetch_unit_buffered.sv
// Fetch stage: running PC into the icache, hits buffered in a prefetch queue for decode.
module fetch_unit_buffered
  import constants_pkg::*;
  import instruction_pkg::*;
#(
  parameter int unsigned          ARCH_LEN  = 32,
  parameter int unsigned          INST_LEN  = 32,
  parameter int unsigned          PHY_LEN   = 20,
  parameter int unsigned          FQ_DEPTH  = 4,
  parameter logic [ARCH_LEN-1:0]  BOOT_ADDR = ARCH_LEN'(DEFAULT_BOOT_ADDR)
) (
  input  logic                clk,
  input  logic                rst,
  output logic [PHY_LEN-1:0]  ic_addr_out,
  output logic                ic_en_out,
  input  logic [INST_LEN-1:0] ic_instr_in,
  input  logic                ic_miss_in,
  input  logic                redirect_in,
  input  logic [ARCH_LEN-1:0] redirect_pc_in,
  input  logic                dec_ready_in,
  output logic                dec_valid_out,
  output logic [INST_LEN-1:0] dec_inst_out,
  output logic [ARCH_LEN-1:0] dec_pc_out,
  output logic [31:0]         miss_cycles_out
);
  typedef struct packed {
    logic [ARCH_LEN-1:0] pc;
    logic [INST_LEN-1:0] inst;
  } entry_t;

  logic [ARCH_LEN-1:0] pc;
  logic                push;
  logic                pop;
  logic                full;
  logic                empty;
  entry_t              wr_entry;
  entry_t              head;

  // Redirect masks both fetch and decode in its own cycle; the flush lands on the next edge.
  assign ic_en_out     = rst & !redirect_in;
  assign ic_addr_out   = pc[PHY_LEN-1:0];
  assign dec_valid_out = !empty & !redirect_in;
  assign pop           = dec_valid_out & dec_ready_in;
  assign push          = ic_en_out & !ic_miss_in & (!full | pop);

  assign wr_entry.pc   = pc;
  assign wr_entry.inst = ic_instr_in;

  assign dec_inst_out  = dec_valid_out ? head.inst : INST_LEN'(NOP_INST);
  assign dec_pc_out    = dec_valid_out ? head.pc   : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc <= BOOT_ADDR;
    end else if (redirect_in) begin
      pc <= redirect_pc_in & ~ARCH_LEN'(3);
    end else if (push) begin
      pc <= pc + ARCH_LEN'(4);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      miss_cycles_out <= '0;
    end else if (ic_en_out && ic_miss_in && miss_cycles_out != '1) begin
      miss_cycles_out <= miss_cycles_out + 32'd1;
    end
  end

  fetch_queue #(
    .entry_t (entry_t),
    .DEPTH   (FQ_DEPTH)
  ) u_queue (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .pop     (pop),
    .flush   (redirect_in),
    .wr_data (wr_entry),
    .head    (head),
    .full    (full),
    .empty   (empty)
  );
endmodule

// File: tb/tb_fetch_unit_buffered.sv
// Directed bench for fetch_unit_buffered with a combinational icache model.
module tb_fetch_unit_buffered;
  logic        clk = 1'b0;
  logic        rst;
  logic [19:0] ic_addr_out;
  logic        ic_en_out;
  logic [31:0] ic_instr_in;
  logic        ic_miss_in;
  logic        redirect_in;
  logic [31:0] redirect_pc_in;
  logic        dec_ready_in;
  logic        dec_valid_out;
  logic [31:0] dec_inst_out;
  logic [31:0] dec_pc_out;
  logic [31:0] miss_cycles_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [19:0] a);
    return {12'hC0D, a};
  endfunction

  assign ic_instr_in = inst_of(ic_addr_out);

  fetch_unit_buffered #(
    .ARCH_LEN  (32),
    .INST_LEN  (32),
    .PHY_LEN   (20),
    .FQ_DEPTH  (4),
    .BOOT_ADDR (32'h0000_0000)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .ic_addr_out     (ic_addr_out),
    .ic_en_out       (ic_en_out),
    .ic_instr_in     (ic_instr_in),
    .ic_miss_in      (ic_miss_in),
    .redirect_in     (redirect_in),
    .redirect_pc_in  (redirect_pc_in),
    .dec_ready_in    (dec_ready_in),
    .dec_valid_out   (dec_valid_out),
    .dec_inst_out    (dec_inst_out),
    .dec_pc_out      (dec_pc_out),
    .miss_cycles_out (miss_cycles_out)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; ic_miss_in = 1'b0; redirect_in = 1'b0;
    redirect_pc_in = '0; dec_ready_in = 1'b1;
    tick(); tick();

    // Reset state
    check("rst_valid", dec_valid_out, 0);
    check("rst_inst", dec_inst_out, 32'h13);
    check("rst_pc", dec_pc_out, 0);
    check("rst_en", ic_en_out, 0);
    check("rst_miss", miss_cycles_out, 0);

    // 1: streaming hits, ready=1
    rst = 1'b1; #1;
    check("t1_addr0", ic_addr_out, 0);
    check("t1_en", ic_en_out, 1);
    check("t1_valid0", dec_valid_out, 0);
    for (int k = 1; k <= 4; k++) begin
      tick();
      check("t1_addr", ic_addr_out, 4*k);
      check("t1_valid", dec_valid_out, 1);
      check("t1_pc", dec_pc_out, 4*(k-1));
      check("t1_inst", dec_inst_out, inst_of(20'(4*(k-1))));
    end

    // 2 and 5: stall fills queue, then full push+pop across pointer wraps
    rst = 1'b0; tick();
    dec_ready_in = 1'b0; rst = 1'b1; #1;
    for (int k = 0; k < 10; k++) begin
      tick();
      check("t2_stall_pc", dec_pc_out, 0);
    end
    check("t2_addr_hold", ic_addr_out, 16);
    check("t2_valid", dec_valid_out, 1);
    dec_ready_in = 1'b1; #1;
    check("t2_head0", dec_pc_out, 0);
    for (int k = 1; k <= 16; k++) begin
      tick();
      check("t5_head", dec_pc_out, 4*k);
      check("t5_inst", dec_inst_out, inst_of(20'(4*k)));
      check("t5_addr", ic_addr_out, 16 + 4*k);
    end

    // 3: misses at PC 8
    redirect_in = 1'b1; redirect_pc_in = 32'h8; #1;
    check("t3_redir_valid", dec_valid_out, 0);
    check("t3_redir_en", ic_en_out, 0);
    tick();
    redirect_in = 1'b0; #1;
    check("t3_addr", ic_addr_out, 8);
    check("t3_empty", dec_valid_out, 0);
    ic_miss_in = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t3_miss_addr", ic_addr_out, 8);
      check("t3_miss_valid", dec_valid_out, 0);
    end
    check("t3_miss_cnt", miss_cycles_out, 3);
    ic_miss_in = 1'b0;
    tick();
    check("t3_hit_pc", dec_pc_out, 8);
    check("t3_hit_inst", dec_inst_out, inst_of(20'h8));
    check("t3_hit_addr", ic_addr_out, 12);
    check("t3_miss_hold", miss_cycles_out, 3);

    // 4: redirect with queue holding 4,8,12
    dec_ready_in = 1'b0; redirect_in = 1'b1; redirect_pc_in = 32'h4;
    tick();
    redirect_in = 1'b0;
    tick(); tick(); tick();
    check("t4_head", dec_pc_out, 4);
    check("t4_addr", ic_addr_out, 16);
    redirect_in = 1'b1; redirect_pc_in = 32'h103; dec_ready_in = 1'b1; #1;
    check("t4_rd_valid", dec_valid_out, 0);
    check("t4_rd_inst", dec_inst_out, 32'h13);
    check("t4_rd_pc", dec_pc_out, 0);
    check("t4_rd_en", ic_en_out, 0);
    tick();
    redirect_in = 1'b0; #1;
    check("t4_flushed", dec_valid_out, 0);
    check("t4_target", ic_addr_out, 20'h100);
    tick();
    check("t4_dec_valid", dec_valid_out, 1);
    check("t4_dec_pc", dec_pc_out, 32'h100);
    check("t4_addr_next", ic_addr_out, 20'h104);

    // 6: asynchronous reset mid-stream
    dec_ready_in = 1'b0; ic_miss_in = 1'b1;
    tick();
    ic_miss_in = 1'b0;
    tick(); tick();
    check("t6_pre_valid", dec_valid_out, 1);
    check("t6_pre_miss", miss_cycles_out, 4);
    #2;
    rst = 1'b0; #1;
    check("t6_valid", dec_valid_out, 0);
    check("t6_inst", dec_inst_out, 32'h13);
    check("t6_pc", dec_pc_out, 0);
    check("t6_miss", miss_cycles_out, 0);
    check("t6_en", ic_en_out, 0);
    tick();
    rst = 1'b1; #1;
    check("t6_boot", ic_addr_out, 0);
    check("t6_empty", dec_valid_out, 0);
    tick();
    check("t6_first_pc", dec_pc_out, 0);
    check("t6_first_valid", dec_valid_out, 1);
    check("t6_addr", ic_addr_out, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_unit_buffered.md
Name: fetch_unit_buffered

Overview:
Parametrised successor to the single-PC fetch stage. It drives the icache with a running PC and pushes each hit {pc, instr} into a circular prefetch queue. Decode drains the queue through a valid/ready handshake. Adds branch/jump redirect with queue flush, configurable depth and boot address, and a saturating miss-cycle counter. It sits between the icache and the decode stage.

Parameters:
ARCH_LEN, 32, PC / architectural width
INST_LEN, 32, instruction width
PHY_LEN, 20, icache physical address width (low bits of PC)
FQ_DEPTH, 4, prefetch queue entries (power of two, >=2)
BOOT_ADDR, 32'h0000_0000, PC after reset

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
ic_addr_out  out  PHY_LEN  icache lookup address = pc[PHY_LEN-1:0]
ic_en_out  out  1  icache lookup enable
ic_instr_in  in  INST_LEN  icache data, valid in the same cycle when ic_miss_in=0
ic_miss_in  in  1  icache miss for the current address
redirect_in  in  1  branch/jump taken; flush and restart fetch
redirect_pc_in  in  ARCH_LEN  redirect target
dec_ready_in  in  1  decode accepts the head entry this cycle
dec_valid_out  out  1  head entry valid
dec_inst_out  out  INST_LEN  head instruction; NOP_INST when not valid
dec_pc_out  out  ARCH_LEN  head PC; 0 when not valid
miss_cycles_out  out  32  saturating count of cycles with ic_en_out=1 and ic_miss_in=1

Behaviour:
- Reset (rst=0, asynchronous): pc=BOOT_ADDR, queue empty (rd_ptr=wr_ptr=0, count=0), miss_cycles_out=0. While in reset: dec_valid_out=0, dec_inst_out=NOP_INST (32'h0000_0013), dec_pc_out=0, ic_en_out=0.
- Out of reset, ic_en_out = !redirect_in.
- pop = dec_valid_out & dec_ready_in.
- push = ic_en_out & !ic_miss_in & (count<FQ_DEPTH | pop). Push and pop in the same cycle on a full queue is legal; count is unchanged.
- Push writes {pc, ic_instr_in} at wr_ptr. wr_ptr wraps modulo FQ_DEPTH, and pc <= pc+4 (mod 2^ARCH_LEN).
- No push (miss or full): pc holds.
- No bypass. Fetch-to-decode latency is 1 cycle minimum; an entry pushed in cycle N is visible at the head in N+1.
- dec_valid_out = (count!=0) & !redirect_in. dec_inst_out and dec_pc_out are the head entry when valid, else NOP_INST and 0.
- Decode stall (dec_ready_in=0): the head and all outputs stay stable. Fetch continues until the queue is full, then pc holds.
- Redirect: redirect_in has priority over push, pop and miss.
  - In the redirect cycle: no push, no pop.
  - Next edge: queue cleared (count=0, pointers to 0) and pc <= {redirect_pc_in[ARCH_LEN-1:2], 2'b00}, so the low 2 bits are forced to zero.
  - The first target instruction can appear at decode no earlier than 2 cycles after redirect_in is asserted.
  - Back-to-back redirects: the last one wins.
- miss_cycles_out increments when ic_en_out & ic_miss_in and saturates at 32'hFFFF_FFFF. Redirect does not clear it.
- count is a $clog2(FQ_DEPTH)+1-bit register. The queue never overflows or underflows; assertions check count<=FQ_DEPTH, pop only when count>0, and push only when there is room.

Decomposition:
- Shared package constants_pkg gets NOP_INST and the default BOOT_ADDR.
- Shared package instruction_pkg gets typedef fetch_entry_t = struct packed {logic [ARCH_LEN-1:0] pc; logic [INST_LEN-1:0] inst;}.
- One sub-module, fetch_queue: parametrised circular FIFO of fetch_entry_t with push, pop, flush, full, empty and head output. The asynchronous active-low reset clears only its pointers and count, not the storage.
- PC register, redirect logic and miss counter stay in fetch_unit_buffered.

Test Plan:
1. Reset release, all hits, dec_ready_in=1 → ic_addr_out goes 0,4,8,… per cycle. Decode sees PC 0 with instr[0] one cycle after the first lookup, then one entry per cycle.
2. dec_ready_in=0 for 10 cycles, FQ_DEPTH=4, all hits → exactly 4 pushes, then pc holds at 16. dec_pc_out stays 0. After release, decode drains PCs 0,4,8,12 and then 16.
3. ic_miss_in=1 for 3 cycles at PC 8 → pc holds at 8 and there are no pushes. miss_cycles_out increases by 3. PC 8 is pushed on the first hit cycle.
4. Queue holding PCs 4,8,12 plus redirect_in=1 with redirect_pc_in=32'h103 → dec_valid_out=0 in the redirect cycle, the queue is empty the next cycle, ic_addr_out=0x100, and the next decoded PC is 0x100.
5. Full queue with dec_ready_in=1 and a hit in the same cycle → count stays 4, the head advances, and a new entry lands at the wrapped wr_ptr. Order is preserved across 3 pointer wraps.
6. rst asserted asynchronously mid-stream with the queue non-empty → outputs immediately go to dec_valid_out=0, dec_inst_out=0x13, miss_cycles_out=0. After release, fetch restarts at BOOT_ADDR.
